// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    ST_UP      = 2'd0,
    ST_WAIT_DN = 2'd1,
    ST_DOWN    = 2'd2,
    ST_WAIT_UP = 2'd3
  } key_st_e;

  // Number of clk cycles a synchronised level must hold before it is accepted.
  function automatic int unsigned db_cycles(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key: 2-FF synchroniser, stability counter and press/release FSM.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic state_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s_n;
  key_st_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Synchroniser resets to "released" so no spurious press follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
    end
  end

  assign s_n = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_UP;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // A reverting level always beats the terminal count, so a last-cycle bounce aborts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_UP: begin
        if (!s_n) begin
          state_d = ST_WAIT_DN;
          cnt_d   = '0;
        end
      end
      ST_WAIT_DN: begin
        if (s_n) begin
          state_d = ST_UP;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DOWN;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DOWN: begin
        if (s_n) begin
          state_d = ST_WAIT_UP;
          cnt_d   = '0;
        end
      end
      ST_WAIT_UP: begin
        if (!s_n) begin
          state_d = ST_DOWN;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_UP;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_UP;
    endcase
    level_d = (state_d == ST_DOWN) || (state_d == ST_WAIT_UP);
  end

  assign state_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces N active-low push-buttons into clean levels and one-cycle press/release events.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned N_KEYS      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  localparam int unsigned DB_CYCLES = db_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);

  if (DB_CYCLES < 2) begin : g_db_check
    $error("key_debounce: DB_CYCLES must be at least 2");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_n_i  (key_n[i]),
      .state_o  (key_state[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES = 8 (8 kHz clock, 1 ms).
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_n;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;

  int checks = 0;
  int errors = 0;

  key_debounce #(
    .CLK_FREQ_HZ(8000),
    .DEBOUNCE_MS(1),
    .N_KEYS     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_n = 4'b1111;
    #3;
    checks++;
    if ({key_state, key_press, key_release} !== 12'h000) begin
      errors++;
      $display("FAIL reset_async: got %h, expected 000", {key_state, key_press, key_release});
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if ({key_state, key_press, key_release} !== 12'h000) begin
      errors++;
      $display("FAIL reset_idle: got %h, expected 000", {key_state, key_press, key_release});
    end
  endtask

  task automatic test_clean_press();
    key_n[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (key_press[0] !== (k == 11) || key_state[0] !== (k >= 11)) begin
        errors++;
        $display("FAIL clean_press cyc %0d: press=%b state=%b, expected press=%b state=%b",
                 k, key_press[0], key_state[0], (k == 11), (k >= 11));
      end
    end
    key_n[0] = 1'b1;
    repeat (12) step();
  endtask

  task automatic test_bounce();
    int presses;
    int pattern_len [4] = '{5, 2, 7, 15};
    logic pattern_val [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int p = 0; p < 4; p++) begin
      key_n[1] = pattern_val[p];
      for (int k = 0; k < pattern_len[p]; k++) begin
        step();
        checks++;
        if (key_press[1] !== 1'b0 || key_release[1] !== 1'b0 || key_state[1] !== 1'b0) begin
          errors++;
          $display("FAIL bounce seg %0d cyc %0d: press=%b release=%b state=%b, expected all 0",
                   p, k, key_press[1], key_release[1], key_state[1]);
        end
      end
    end
    presses = 0;
    key_n[1] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (key_press[1] === 1'b1) presses++;
    end
    checks++;
    if (presses != 1 || key_state[1] !== 1'b1) begin
      errors++;
      $display("FAIL bounce_hold: presses=%0d state=%b, expected presses=1 state=1",
               presses, key_state[1]);
    end
    key_n[1] = 1'b1;
    repeat (12) step();
  endtask

  task automatic test_final_abort();
    int rels;
    key_n[3] = 1'b0;
    repeat (8) step();
    key_n[3] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      checks++;
      if (key_press[3] !== 1'b0 || key_state[3] !== 1'b0) begin
        errors++;
        $display("FAIL abort_press cyc %0d: press=%b state=%b, expected press=0 state=0",
                 k, key_press[3], key_state[3]);
      end
    end
    key_n[3] = 1'b0;
    repeat (12) step();
    checks++;
    if (key_state[3] !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: state=%b, expected 1", key_state[3]);
    end
    key_n[3] = 1'b1;
    repeat (8) step();
    key_n[3] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      checks++;
      if (key_release[3] !== 1'b0 || key_state[3] !== 1'b1) begin
        errors++;
        $display("FAIL abort_release cyc %0d: release=%b state=%b, expected release=0 state=1",
                 k, key_release[3], key_state[3]);
      end
    end
    rels = 0;
    key_n[3] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (key_release[3] === 1'b1) rels++;
    end
    checks++;
    if (rels != 1 || key_state[3] !== 1'b0) begin
      errors++;
      $display("FAIL abort_cleanup: releases=%0d state=%b, expected releases=1 state=0",
               rels, key_state[3]);
    end
  endtask

  task automatic test_release();
    key_n[2] = 1'b0;
    repeat (12) step();
    checks++;
    if (key_state[2] !== 1'b1) begin
      errors++;
      $display("FAIL release_setup: state=%b, expected 1", key_state[2]);
    end
    key_n[2] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (key_release[2] !== (k == 11) || key_state[2] !== (k < 11) || key_press[2] !== 1'b0) begin
        errors++;
        $display("FAIL release cyc %0d: release=%b state=%b press=%b, expected release=%b state=%b press=0",
                 k, key_release[2], key_state[2], key_press[2], (k == 11), (k < 11));
      end
    end
  endtask

  task automatic test_simultaneous();
    key_n = 4'b0000;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (key_press !== ((k == 11) ? 4'b1111 : 4'b0000)) begin
        errors++;
        $display("FAIL simul_press cyc %0d: press=%b, expected %b",
                 k, key_press, ((k == 11) ? 4'b1111 : 4'b0000));
      end
    end
    key_n = 4'b1111;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (key_release !== ((k == 11) ? 4'b1111 : 4'b0000)) begin
        errors++;
        $display("FAIL simul_release cyc %0d: release=%b, expected %b",
                 k, key_release, ((k == 11) ? 4'b1111 : 4'b0000));
      end
    end
  endtask

  task automatic test_reset_cases();
    // Reset while in WAIT_DN with cnt=4 (entered at E2, count 4 after E6).
    key_n[0] = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_state, key_press, key_release} !== 12'h000) begin
      errors++;
      $display("FAIL reset_waitdn: got %h, expected 000", {key_state, key_press, key_release});
    end
    key_n[0] = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      checks++;
      if ({key_state, key_press, key_release} !== 12'h000) begin
        errors++;
        $display("FAIL reset_waitdn_after cyc %0d: got %h, expected 000",
                 k, {key_state, key_press, key_release});
      end
    end
    // Reset while DOWN with the key still held across reset.
    key_n[0] = 1'b0;
    repeat (12) step();
    checks++;
    if (key_state[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_down_setup: state=%b, expected 1", key_state[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_state, key_press, key_release} !== 12'h000) begin
      errors++;
      $display("FAIL reset_down: got %h, expected 000", {key_state, key_press, key_release});
    end
    repeat (3) step();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (key_press[0] !== (k == 11) || key_state[0] !== (k >= 11) || key_release[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_held cyc %0d: press=%b state=%b release=%b, expected press=%b state=%b release=0",
                 k, key_press[0], key_state[0], key_release[0], (k == 11), (k >= 11));
      end
    end
    key_n[0] = 1'b1;
    repeat (12) step();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_final_abort();
    test_release();
    test_simultaneous();
    test_reset_cases();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounces the board's active-low push-buttons and turns them into clean levels and single-cycle press/release events. It is the input-side counterpart of the LED driver: keys come in from the pins, and the outputs go to user logic such as LED pattern selection. Each key has a 2-FF synchroniser and an independent 4-state debounce FSM with its own counter.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: `clk` frequency in Hz.
- `DEBOUNCE_MS`, default 20: required stable time in ms.
- `N_KEYS`, default 4: number of keys.
- Derived constant `DB_CYCLES = (CLK_FREQ_HZ/1000)*DEBOUNCE_MS`. It must be at least 2; elaboration fails otherwise.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `key_n`  in  N_KEYS  raw pins; asynchronous; 0 = pressed.
- `key_state`  out  N_KEYS  debounced level; 1 = pressed.
- `key_press`  out  N_KEYS  one-cycle pulse on a debounced press.
- `key_release`  out  N_KEYS  one-cycle pulse on a debounced release.

## Operation
- **Synchroniser:** 2 FFs per key, both reset to 1 (released). The second FF output is `s_n`.
- **Counter:** one per key, width `$clog2(DB_CYCLES)`.
- **FSM per key:**
  - UP: `key_state`=0. If `s_n`=0, go to WAIT_DN with cnt=0.
  - WAIT_DN: if `s_n`=1, go to UP with no event (bounce). Else if cnt==DB_CYCLES-1, go to DOWN and pulse `key_press`. Else cnt+1.
  - DOWN: `key_state`=1. If `s_n`=1, go to WAIT_UP with cnt=0.
  - WAIT_UP: if `s_n`=0, go to DOWN with no event. Else if cnt==DB_CYCLES-1, go to UP and pulse `key_release`. Else cnt+1.
- **Output meaning:** `key_state` is 1 exactly in DOWN and WAIT_UP. WAIT_DN still reports released; WAIT_UP still reports pressed.
- **Events:** `key_press` and `key_release` are registered and high for exactly one cycle, on the same edge as the state transition. They are never both high for the same key.
- **Independence:** keys share no state. Any combination of keys may produce events in the same cycle.
- **Counter range:** cnt never exceeds DB_CYCLES-1, so no wrap or saturation is needed.

## Timing
- **Reset values:** all FSMs in UP, cnt=0, sync FFs=1. `key_state`, `key_press` and `key_release` are all 0. Reset takes effect immediately on the `rst_n` fall; the first active edge is the first `clk` rise after `rst_n` rises.
- **Press latency:** edge E0 is the first edge that samples `key_n`=0, with the pin held low thereafter. `s_n`=0 after E1, WAIT_DN after E2, and DOWN with `key_press`=1 and `key_state`=1 after E(DB_CYCLES+2). Release latency is symmetric.
- **Glitch filtering:** a pin change lasting at most 1 cycle may be missed by the synchroniser. Any change that reaches `s_n` restarts or aborts the debounce.
- **Bounce in the final cycle:** if `s_n` reverts on the cycle where cnt==DB_CYCLES-1, the abort wins. No event is generated and the FSM returns to UP (or DOWN).
- **Reset mid-debounce or while DOWN:** the FSM returns to UP with no release pulse. If the key is still held after reset, a normal press is detected DB_CYCLES+2 cycles later.

## Structure
- **Package `key_pkg`:** FSM state enum (UP, WAIT_DN, DOWN, WAIT_UP) as a 2-bit typedef, and a function `db_cycles(clk_hz, ms)` that computes the derived constant.
- **Sub-module `key_debounce_ch`:** one key, containing the synchroniser, counter and FSM, with parameter DB_CYCLES. The top level instantiates it N_KEYS times in a generate loop and concatenates the outputs.

## Test plan
All scenarios use `CLK_FREQ_HZ`=8000, `DEBOUNCE_MS`=1, so DB_CYCLES=8, N_KEYS=4.
1. **Clean press:** `key_n[0]` goes 1→0 and is held. `key_press[0]` is a single pulse 10 cycles after the sampling edge. `key_state[0]` goes 1 on the same cycle and stays 1.
2. **Bounce rejection:** `key_n[1]` toggles low 5 cycles, high 2 cycles, low 7 cycles, then high. There are no pulses and `key_state[1]` stays 0. A following low-hold of 20 cycles gives exactly one press.
3. **Final-cycle abort:** `s_n` goes high exactly when cnt=7 in WAIT_DN. No `key_press` and FSM returns to UP. The same check applies to release from DOWN: `key_state` stays 1.
4. **Release:** from DOWN, `key_n[2]` goes high and is held. `key_release[2]` pulses 10 cycles later and `key_state[2]` falls on the same cycle.
5. **Simultaneous keys:** all four keys are pressed on the same edge. All four `key_press` bits pulse on the same cycle, giving 4'b1111 for one cycle.
6. **Reset cases:**
   - Assert `rst_n`=0 while in WAIT_DN at cnt=4: outputs 0 immediately, no pulse.
   - Key held through reset release: `key_press` fires 10 cycles after the first post-reset edge.
